// File: rtl/gpio_uart_tx.sv
// Watches a 32-bit GPIO word and prints every change on a UART TX line
// as 8 uppercase hex digits followed by CR LF.
module gpio_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [31:0]   prev_q;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   word_q, word_n;
    logic [3:0]    char_idx, char_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [TW-1:0] timer, timer_n;
    logic          tx_q, tx_n;
    logic          pop, push, full, accept, tick;

    function automatic logic [7:0] char_of(input logic [31:0] w, input logic [3:0] idx);
        logic [31:0] s;
        logic [3:0]  n;
        s = w << {idx[2:0], 2'b00};
        n = s[31:28];
        if (idx == 4'd8)      char_of = 8'h0D;
        else if (idx == 4'd9) char_of = 8'h0A;
        else if (n < 4'd10)   char_of = 8'h30 + {4'h0, n};
        else                  char_of = 8'h37 + {4'h0, n};
    endfunction

    assign push   = data_in != prev_q;
    assign full   = count == CW'(FIFO_DEPTH);
    // A pop on the same edge frees the slot a full FIFO needs.
    assign accept = push & (~full | pop);
    assign tick   = timer == LAST;

    assign tx   = tx_q;
    assign busy = (state != IDLE) | (count != '0);

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) prev_q <= data_in;
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (accept & ~pop) count <= count + CW'(1);
            else if (~accept & pop) count <= count - CW'(1);
            if (push & ~accept) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_q   <= '0;
            char_idx <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            timer    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            word_q   <= word_n;
            char_idx <= char_idx_n;
            shreg    <= shreg_n;
            bit_idx  <= bit_idx_n;
            timer    <= timer_n;
            tx_q     <= tx_n;
        end
    end

    always_comb begin
        state_n    = state;
        word_n     = word_q;
        char_idx_n = char_idx;
        shreg_n    = shreg;
        bit_idx_n  = bit_idx;
        timer_n    = tick ? '0 : timer + TW'(1);
        tx_n       = tx_q;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                timer_n = '0;
                if (count != '0) begin
                    pop        = 1'b1;
                    word_n     = mem[rd_ptr];
                    char_idx_n = '0;
                    shreg_n    = char_of(mem[rd_ptr], 4'd0);
                    tx_n       = 1'b0;
                    state_n    = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_n      = shreg[0];
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg[1];
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (char_idx < 4'd9) begin
                        char_idx_n = char_idx + 4'd1;
                        shreg_n    = char_of(word_q, char_idx + 4'd1);
                        tx_n       = 1'b0;
                        state_n    = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
